// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the IFU and the LSU using round-robin arbitration.
// There is a single outstanding transaction, a response timeout, and illegal-length rejection.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [2:0]  lsu_len,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_len,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        err,
    output logic        busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           r_state;
    logic             r_last_lsu;
    logic             r_master_lsu;
    logic             r_wen;
    logic [31:0]      r_addr;
    logic [2:0]       r_len;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic w_idle;
    logic w_grant_ifu;
    logic w_grant_lsu;
    logic w_resp;

    function automatic logic len_legal(input logic [2:0] len);
        return (len == 3'd1) || (len == 3'd2) || (len == 3'd4);
    endfunction

    // On a tie, the master that did not win last time is served.
    assign w_idle      = (r_state == S_IDLE);
    assign w_grant_lsu = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);
    assign w_grant_ifu = ifu_req_valid && (!lsu_req_valid || r_last_lsu);

    assign ifu_req_ready = w_idle && w_grant_ifu;
    assign lsu_req_ready = w_idle && w_grant_lsu;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_lsu   <= 1'b0;
            r_master_lsu <= 1'b0;
            r_wen        <= 1'b0;
            r_addr       <= '0;
            r_len        <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (lsu_req_ready) begin
                        r_master_lsu <= 1'b1;
                        r_last_lsu   <= 1'b1;
                        r_wen        <= lsu_wen;
                        r_addr       <= lsu_addr;
                        r_len        <= lsu_len;
                        r_wdata      <= lsu_wdata;
                        if (len_legal(lsu_len)) begin
                            r_state <= S_ISSUE;
                        end else begin
                            r_rdata <= ERR_DATA;
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end
                    end else if (ifu_req_ready) begin
                        r_master_lsu <= 1'b0;
                        r_last_lsu   <= 1'b0;
                        r_wen        <= 1'b0;
                        r_addr       <= ifu_addr;
                        r_len        <= 3'd4;
                        r_wdata      <= '0;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response arriving on the timeout cycle still counts as a success.
                    if (mem_resp_valid) begin
                        r_rdata <= r_wen ? 32'd0 : mem_rdata;
                        r_state <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rdata <= ERR_DATA;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_resp = (r_state == S_RESP);

    assign mem_req_valid  = (r_state == S_ISSUE);
    assign mem_wen        = r_wen;
    assign mem_addr       = r_addr;
    assign mem_len        = {29'd0, r_len};
    assign mem_wdata      = r_wdata;

    assign ifu_resp_valid = w_resp && !r_master_lsu;
    assign lsu_resp_valid = w_resp && r_master_lsu;
    assign ifu_rdata      = ifu_resp_valid ? r_rdata : 32'd0;
    assign lsu_rdata      = lsu_resp_valid ? r_rdata : 32'd0;
    assign err            = r_err;
    assign busy           = !w_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
// It also includes hand-computed checks for latency, grant order, timeout and reset.
module tb_mem_port_arbiter;

    localparam int          TO   = 64;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [2:0]  lsu_len = '0;
    logic [31:0] lsu_wdata = '0;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_len;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;
    logic        busy;

    always #5 clock = ~clock;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERRD)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_len(lsu_len), .lsu_wdata(lsu_wdata),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_len(mem_len), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .err(err), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner 0=none 1=IFU 2=LSU; wait count -1 when not waiting on memory
    int          m_own = 0;
    int          m_wait = -1;
    bit          m_last_lsu = 1'b0;
    bit          m_issue = 1'b0;
    bit          m_deliver = 1'b0;
    bit          m_err = 1'b0;
    logic        m_wen = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic [2:0]  m_len = '0;

    function automatic bit pick_lsu();
        if (lsu_req_valid && ifu_req_valid) return !m_last_lsu;
        return lsu_req_valid;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_own = 0; m_wait = -1; m_last_lsu = 1'b0; m_issue = 1'b0;
            m_deliver = 1'b0; m_err = 1'b0; m_wen = 1'b0; m_addr = '0;
            m_wdata = '0; m_rdata = '0; m_len = '0;
        end else if (m_own == 0) begin
            if (lsu_req_valid || ifu_req_valid) begin
                if (pick_lsu()) begin
                    m_own = 2; m_last_lsu = 1'b1;
                    m_wen = lsu_wen; m_addr = lsu_addr; m_len = lsu_len; m_wdata = lsu_wdata;
                end else begin
                    m_own = 1; m_last_lsu = 1'b0;
                    m_wen = 1'b0; m_addr = ifu_addr; m_len = 3'd4; m_wdata = '0;
                end
                if (m_own == 2 && !(m_len inside {3'd1, 3'd2, 3'd4})) begin
                    m_deliver = 1'b1; m_err = 1'b1; m_rdata = ERRD;
                end else begin
                    m_issue = 1'b1;
                end
            end
        end else if (m_issue) begin
            if (mem_req_ready) begin
                m_issue = 1'b0; m_wait = 0;
            end
        end else if (m_wait >= 0) begin
            if (mem_resp_valid) begin
                m_rdata = m_wen ? 32'd0 : mem_rdata;
                m_err = 1'b0; m_deliver = 1'b1; m_wait = -1;
            end else if (m_wait == TO - 1) begin
                m_rdata = ERRD; m_err = 1'b1; m_deliver = 1'b1; m_wait = -1;
            end else begin
                m_wait++;
            end
        end else if (m_deliver) begin
            m_deliver = 1'b0; m_err = 1'b0; m_own = 0;
        end
    end

    logic e_ir, e_lr, e_iv, e_lv;
    always @(negedge clock) begin
        e_lr = (m_own == 0) && lsu_req_valid && pick_lsu();
        e_ir = (m_own == 0) && ifu_req_valid && !pick_lsu();
        e_iv = m_deliver && (m_own == 1);
        e_lv = m_deliver && (m_own == 2);
        chk1("ifu_req_ready", ifu_req_ready, e_ir);
        chk1("lsu_req_ready", lsu_req_ready, e_lr);
        chk1("busy", busy, m_own != 0);
        chk1("mem_req_valid", mem_req_valid, m_issue);
        if (m_issue) begin
            chk1("mem_wen", mem_wen, m_wen);
            chk32("mem_addr", mem_addr, m_addr);
            chk32("mem_len", mem_len, {29'd0, m_len});
            if (m_wen) chk32("mem_wdata", mem_wdata, m_wdata);
        end
        chk1("ifu_resp_valid", ifu_resp_valid, e_iv);
        chk32("ifu_rdata", ifu_rdata, e_iv ? m_rdata : 32'd0);
        chk1("lsu_resp_valid", lsu_resp_valid, e_lv);
        chk32("lsu_rdata", lsu_rdata, e_lv ? m_rdata : 32'd0);
        chk1("err", err, m_deliver && m_err);
    end

    // Memory responder: ready after 'stall' cycles of request, data one cycle after handshake
    int          stall = 0;
    int          vcount = 0;
    bit          resp_en = 1'b1;
    bit          inject = 1'b0;
    bit          hs = 1'b0;
    logic [31:0] rd_val = '0;
    initial begin
        forever begin
            @(negedge clock);
            hs = mem_req_valid && mem_req_ready && !reset;
            @(posedge clock);
            #1;
            mem_resp_valid = (hs && resp_en) || inject;
            mem_rdata = rd_val;
            if (mem_req_valid) begin
                mem_req_ready = (vcount >= stall);
                vcount++;
            end else begin
                vcount = 0;
                mem_req_ready = (stall == 0);
            end
        end
    end

    int q_grant[$];
    bit log_en = 1'b0;
    always @(negedge clock) begin
        if (log_en) begin
            if (ifu_req_ready) q_grant.push_back(1);
            if (lsu_req_ready) q_grant.push_back(2);
        end
    end

    task automatic lsu_req(input logic w, input logic [31:0] a, input logic [2:0] l,
                           input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        lsu_wen = w; lsu_addr = a; lsu_len = l; lsu_wdata = d; lsu_req_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (lsu_req_ready) ok = 1'b1;
            else begin @(posedge clock); #1; end
        end
        @(posedge clock); #1;
        lsu_req_valid = 1'b0;
        chk1("lsu_accept", ok, 1'b1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clock);
            if (!busy) idle = 1'b1;
        end
        @(posedge clock); #1;
        chk1("return_to_idle", idle, 1'b1);
    endtask

    task automatic pulse_stray_resp();
        @(negedge clock); inject = 1'b1;
        @(negedge clock); inject = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk1("stray_ifu_resp", ifu_resp_valid, 1'b0);
            chk1("stray_lsu_resp", lsu_resp_valid, 1'b0);
        end
        @(posedge clock); #1;
    endtask

    int exp_order[4] = '{2, 1, 2, 1};
    int mcnt, cyc, hsc;
    bit got, ok;

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk1("rst_ifu_resp", ifu_resp_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clock); #1;

        // IFU fetch with zero-wait memory
        rd_val = 32'h0000_0413;
        ifu_addr = 32'h8000_0000; ifu_req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (ifu_req_ready) ok = 1'b1;
            else begin @(posedge clock); #1; end
        end
        chk1("ifu_accept", ok, 1'b1);
        @(posedge clock); #1; ifu_req_valid = 1'b0;
        @(negedge clock);
        chk1("fetch_mem_valid_T1", mem_req_valid, 1'b1);
        chk32("fetch_mem_len_T1", mem_len, 32'd4);
        chk1("fetch_mem_wen_T1", mem_wen, 1'b0);
        @(negedge clock);
        @(negedge clock);
        chk1("fetch_resp_T3", ifu_resp_valid, 1'b1);
        chk32("fetch_rdata_T3", ifu_rdata, 32'h0000_0413);
        chk1("fetch_no_lsu_resp", lsu_resp_valid, 1'b0);
        @(posedge clock); #1;
        wait_idle();

        // LSU store with three stall cycles
        stall = 3;
        lsu_req(1'b1, 32'h8000_1000, 3'd2, 32'h0000_1234);
        mcnt = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (mem_req_valid) mcnt++;
            if (lsu_resp_valid) begin
                got = 1'b1;
                chk32("store_rdata", lsu_rdata, 32'd0);
                chk1("store_busy_at_resp", busy, 1'b1);
            end
        end
        chk32("store_issue_cycles", 32'(mcnt), 32'd4);
        chk1("store_resp_seen", got, 1'b1);
        @(posedge clock); #1;
        stall = 0;
        wait_idle();

        // Fresh reset, then both masters request continuously
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        rd_val = 32'hCAFE_0001;
        ifu_addr = 32'h8000_0100;
        lsu_wen = 1'b0; lsu_addr = 32'h8000_2000; lsu_len = 3'd4; lsu_wdata = '0;
        log_en = 1'b1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        for (int i = 0; i < 60 && q_grant.size() < 4; i++) @(negedge clock);
        @(posedge clock); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        log_en = 1'b0;
        chk32("grant_count", 32'(q_grant.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk32("grant_order", 32'(q_grant[i]), 32'(exp_order[i]));
        wait_idle();

        // LSU load that memory never answers
        resp_en = 1'b0;
        lsu_req(1'b0, 32'h8000_3000, 3'd4, 32'd0);
        hsc = -1000; cyc = 0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            cyc++;
            if (mem_req_valid && mem_req_ready) hsc = cyc;
            if (lsu_resp_valid) begin
                got = 1'b1;
                chk32("timeout_latency", 32'(cyc - hsc), 32'd65);
                chk1("timeout_err", err, 1'b1);
                chk32("timeout_rdata", lsu_rdata, ERRD);
            end
        end
        chk1("timeout_resp_seen", got, 1'b1);
        @(posedge clock); #1;
        wait_idle();
        pulse_stray_resp();

        // Illegal length is rejected without touching memory
        resp_en = 1'b1;
        lsu_req(1'b0, 32'h8000_4000, 3'd3, 32'd0);
        @(negedge clock);
        chk1("badlen_err", err, 1'b1);
        chk1("badlen_resp", lsu_resp_valid, 1'b1);
        chk32("badlen_rdata", lsu_rdata, ERRD);
        chk1("badlen_no_mem", mem_req_valid, 1'b0);
        @(posedge clock); #1;
        wait_idle();

        // Asynchronous reset while waiting on memory
        resp_en = 1'b0;
        lsu_req(1'b0, 32'h8000_5000, 3'd4, 32'd0);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        chk1("pre_reset_busy", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("async_rst_busy", busy, 1'b0);
        chk1("async_rst_mem_valid", mem_req_valid, 1'b0);
        chk1("async_rst_lsu_resp", lsu_resp_valid, 1'b0);
        chk1("async_rst_ifu_resp", ifu_resp_valid, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        pulse_stray_resp();
        resp_en = 1'b1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        @(negedge clock);
        chk1("post_reset_tie_lsu", lsu_req_ready, 1'b1);
        chk1("post_reset_tie_ifu", ifu_req_ready, 1'b0);
        @(posedge clock); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
